// File: rtl/imem_axil_loader_if.sv
// imem_axil_loader_if: AXI4-Lite bus bundle between host interconnect and loader.
// master drives requests; slave returns ready/response.
interface imem_axil_loader_if;
  logic [11:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  modport slave (
    input  s_awaddr, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready,
    input  s_araddr, s_arvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awaddr, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready,
    output s_araddr, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/imem_axil_loader.sv
// imem_axil_loader: AXI4-Lite host port for instruction load and run control.
// Define LOADER_CYCLE_CNT_EN to build the CYCLES counter and run timeout.
module imem_axil_loader #(
  parameter int          IMEM_AW        = 8,
  parameter logic [31:0] MAX_RUN_CYCLES = 32'd1_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  imem_axil_loader_if.slave  s,
  output logic               instruction_write,
  output logic [31:0]        instruction_data,
  output logic [IMEM_AW-1:0] instruction_addr,
  output logic               mem_reset_n,
  output logic               core_running,
  output logic               core_done,
  input  logic               core_halt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  state_t      state;
  logic        aw_held;
  logic        w_held;
  logic [9:0]  aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        st_done;
  logic        st_timeout;
  logic        st_halted;
  logic [1:0]  mrst_cnt;
`ifdef LOADER_CYCLE_CNT_EN
  logic [31:0] cycles;
`endif

  logic        wr_go;
  logic        wr_ctrl;
  logic        wr_imem;
  logic        imem_ok;
  logic        do_start;
  logic        do_mrst;
  logic        hit_tmo;
  logic [1:0]  wr_resp;
  logic [9:0]  ar_idx;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        unused;

  assign s.s_awready = !aw_held && !s.s_bvalid;
  assign s.s_wready  = !w_held && !s.s_bvalid;
  assign s.s_arready = !s.s_rvalid;
  assign unused = &{1'b0, s.s_awaddr[1:0], s.s_araddr[1:0]};

  always_comb begin
    wr_go    = aw_held && w_held;
    wr_ctrl  = aw_addr == 10'd0;
    wr_imem  = aw_addr[9:8] == 2'b01;
    imem_ok  = wr_imem && state != RUN && w_strb == 4'hF;
    do_start = wr_go && wr_ctrl && w_data[0];
    do_mrst  = wr_go && wr_ctrl && w_data[1];
`ifdef LOADER_CYCLE_CNT_EN
    hit_tmo  = cycles == MAX_RUN_CYCLES - 32'd1;
`else
    hit_tmo  = 1'b0;
`endif
    wr_resp  = SLVERR;
    unique case (1'b1)
      wr_ctrl: wr_resp = OKAY;
      wr_imem: wr_resp = imem_ok ? OKAY : SLVERR;
      default: wr_resp = SLVERR;
    endcase
  end

  // IMEM window and unmapped space fall to the default arm
  always_comb begin
    ar_idx  = s.s_araddr[11:2];
    rd_data = '0;
    rd_resp = OKAY;
    unique case (1'b1)
      ar_idx == 10'd0: rd_data = '0;
      ar_idx == 10'd1:
        rd_data = {28'd0, st_halted, st_timeout,
                   st_done, state == RUN};
`ifdef LOADER_CYCLE_CNT_EN
      ar_idx == 10'd2: rd_data = cycles;
`else
      ar_idx == 10'd2: rd_data = '0;
`endif
      default: rd_resp = SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      aw_addr           <= '0;
      w_data            <= '0;
      w_strb            <= '0;
      s.s_bvalid        <= 1'b0;
      s.s_bresp         <= OKAY;
      s.s_rvalid        <= 1'b0;
      s.s_rresp         <= OKAY;
      s.s_rdata         <= '0;
      instruction_write <= 1'b0;
      instruction_data  <= '0;
      instruction_addr  <= '0;
      mem_reset_n       <= 1'b1;
      mrst_cnt          <= '0;
      core_running      <= 1'b0;
      core_done         <= 1'b0;
      st_done           <= 1'b0;
      st_timeout        <= 1'b0;
      st_halted         <= 1'b0;
`ifdef LOADER_CYCLE_CNT_EN
      cycles            <= '0;
`endif
    end else begin
      instruction_write <= 1'b0;
      core_done         <= 1'b0;

      if (s.s_awvalid && s.s_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s.s_awaddr[11:2];
      end
      if (s.s_wvalid && s.s_wready) begin
        w_held <= 1'b1;
        w_data <= s.s_wdata;
        w_strb <= s.s_wstrb;
      end
      if (s.s_bvalid && s.s_bready)
        s.s_bvalid <= 1'b0;
      if (wr_go) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        s.s_bvalid <= 1'b1;
        s.s_bresp  <= wr_resp;
        if (imem_ok) begin
          instruction_write <= 1'b1;
          instruction_data  <= w_data;
          instruction_addr  <= aw_addr[IMEM_AW-1:0];
        end
      end

      if (s.s_rvalid && s.s_rready)
        s.s_rvalid <= 1'b0;
      if (s.s_arvalid && s.s_arready) begin
        s.s_rvalid <= 1'b1;
        s.s_rdata  <= rd_data;
        s.s_rresp  <= rd_resp;
      end

      // a new MEM_RST restarts the 4-cycle low window
      if (do_mrst) begin
        mem_reset_n <= 1'b0;
        mrst_cnt    <= 2'd3;
      end else if (!mem_reset_n) begin
        if (mrst_cnt == 2'd0)
          mem_reset_n <= 1'b1;
        else
          mrst_cnt <= mrst_cnt - 2'd1;
      end

      unique case (state)
        IDLE, DONE: begin
          if (do_start) begin
            state        <= RUN;
            core_running <= 1'b1;
            st_done      <= 1'b0;
            st_timeout   <= 1'b0;
            st_halted    <= 1'b0;
`ifdef LOADER_CYCLE_CNT_EN
            cycles       <= '0;
`endif
          end
        end
        RUN: begin
          if (do_mrst) begin
            state        <= IDLE;
            core_running <= 1'b0;
          end else begin
`ifdef LOADER_CYCLE_CNT_EN
            cycles <= cycles + 32'd1;
`endif
            if (core_halt || hit_tmo) begin
              state        <= DONE;
              core_running <= 1'b0;
              core_done    <= 1'b1;
              st_done      <= 1'b1;
              st_halted    <= core_halt;
              st_timeout   <= hit_tmo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_axil_loader.md
# imem_axil_loader

AXI4-Lite slave that acts as the host-side end of the single-cycle RISC-V core's instruction-load and run-control interface. It converts bus writes into the core's instruction-memory write strobes. It also starts and stops program execution by driving the core's running/done inputs, and reports run status and cycle count back over the bus. It sits between the PS/host AXI interconnect and the core top level.

## Interface
Parameters:
- `IMEM_AW`, 8 — instruction word-address width; instruction memory depth is 2^IMEM_AW words.
- `MAX_RUN_CYCLES`, 32'd1_000_000 — run timeout in clock cycles; must be ≥1.

Ports:
- `clk`  in  1 — single clock.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `s_awaddr` in 12, `s_awvalid` in 1, `s_awready` out 1 — AXI4-Lite write-address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1 — write-data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1 — write-response channel.
- `s_araddr` in 12, `s_arvalid` in 1, `s_arready` out 1 — read-address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1 — read-data channel.
- `instruction_write`  out  1 — one-cycle write strobe to instruction memory.
- `instruction_data`  out  32 — instruction word.
- `instruction_addr`  out  IMEM_AW — instruction word address.
- `mem_reset_n`  out  1 — active-low instruction/data memory reset.
- `core_running`  out  1 — level, high while the core executes.
- `core_done`  out  1 — one-cycle pulse when a run ends.
- `core_halt`  in  1 — core request to end the run (ecall/ebreak decoded).

## Operation
Register map (byte address; bits [1:0] ignored):
- 0x000 CTRL (write-only): bit0 START; bit1 MEM_RST. Writing 1 triggers the action; writing 0 has no effect.
- 0x004 STATUS (read-only): bit0 running; bit1 done (sticky); bit2 timeout (sticky); bit3 halted (sticky).
- 0x008 CYCLES (read-only): cycles spent in RUN during the last or current run.
- 0x400–0x7FC IMEM window: word index = addr[IMEM_AW+1:2]. IMEM_AW ≤ 8 is required.
- Any other address returns SLVERR. Reads of unmapped addresses return 0.

Write path:
- AW and W are captured independently into holding registers. `s_awready` = !aw_held && !s_bvalid; `s_wready` = !w_held && !s_bvalid.
- Once both are held, the write executes on the next edge, `s_bvalid` rises, and both holding registers clear.
- IMEM write accepted only in IDLE/DONE with wstrb=4'hF: `instruction_write`=1 for exactly one cycle, with data/addr valid in the same cycle; OKAY.
- IMEM write during RUN, or with partial wstrb: no strobe, SLVERR.
- Writes to STATUS/CYCLES: SLVERR, no effect.

Read path:
- `s_arready` = !s_rvalid. The AR handshake loads `s_rdata`/`s_rresp`, and `s_rvalid` rises on the next edge.
- The IMEM window is not readable: it returns 0 with SLVERR.

Run FSM: IDLE → RUN → DONE.
- IDLE/DONE + START: go to RUN; CYCLES←0; clear done/timeout/halted.
- RUN: `core_running`=1; CYCLES increments every cycle.
- RUN exit conditions:
  - `core_halt`=1: go to DONE with halted=1.
  - CYCLES reaching MAX_RUN_CYCLES−1: go to DONE with timeout=1.
  - Both in the same cycle: both bits set.
- On entering DONE: `core_done` pulses for 1 cycle; done=1.
- START while in RUN is ignored but still returns OKAY.
- MEM_RST: `mem_reset_n` is driven low for exactly 4 cycles. It is accepted in any state. In RUN it also forces the FSM to IDLE, with no done pulse.

## Timing
- Reset values: `s_bvalid`/`s_rvalid`=0; `s_bresp`/`s_rresp`/`s_rdata`=0; `instruction_write`=0; `instruction_data`/`instruction_addr`=0; `mem_reset_n`=1; `core_running`=0; `core_done`=0. The FSM resets to IDLE and all status bits and CYCLES reset to 0.
- The ready outputs are combinational from state, so they are 1 while in reset.
- Write latency: from the edge on which the second of AW/W is captured, `s_bvalid` and `instruction_write` (or the CTRL action) occur 1 edge later.
- `core_running` rises 1 cycle after the START write executes.
- `core_halt` is sampled on the edge: `core_running` falls and `core_done` pulses in the cycle after it is seen high.
- `s_bvalid` and `s_rvalid` hold until `s_bready`/`s_rready`. Holding registers stall further AW/W while `s_bvalid` is high.
- Asserting `reset_n` mid-transaction discards any held AW/W, pending response, or run in progress; no strobe is generated.

## Configuration
- `LOADER_CYCLE_CNT_EN` defined: the CYCLES register and the MAX_RUN_CYCLES timeout are present.
- Not defined: CYCLES reads as 0 with OKAY, there is no counter, and timeout never fires. A run ends only on `core_halt` or MEM_RST.

## Test plan
- Write 0x00500093 to 0x404 → one `instruction_write` pulse with addr=1 and data=0x00500093; bresp=OKAY.
- AW issued 3 cycles before W → the write executes exactly once, 1 edge after W is captured; bvalid is held for 5 cycles with bready=0.
- START, then `core_halt` after 10 cycles → `core_running` high for 10 cycles; one `core_done` pulse; STATUS=0xA; CYCLES=10.
- MAX_RUN_CYCLES=16, halt never asserted → DONE after 16 running cycles; STATUS=0x6.
- IMEM write during RUN → SLVERR, no strobe. Read from 0x0C0 → SLVERR, rdata=0.
- MEM_RST write during RUN → `mem_reset_n` low for 4 cycles; FSM in IDLE; no `core_done` pulse; STATUS=0.
